// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional macro ALU_ARB_STATS_EN adds grant_cnt0/grant_cnt1/err_cnt statistics outputs.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW = 4,
  parameter int TAGW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [TAGW-1:0]  req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic [TAGW-1:0]  req1_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_port,
  output logic [TAGW-1:0]  resp_tag,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      grant_cnt0,
  output logic [31:0]      grant_cnt1,
  output logic [15:0]      err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nxt;
  logic last_grant, gnt, hs, port_q, illegal;
  logic [TAGW-1:0] tag_q;
  // on contention the port that did not win last time is chosen
  assign gnt = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign hs = req0_ready | req1_ready;
  assign illegal = alu_op > OPW'(7);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = (state == IDLE) ? (hs ? EXEC : IDLE) :
          (state == EXEC) ? RESP :
          (resp_ready ? IDLE : RESP);
  always_comb begin
    req0_ready = ~reset & (state == IDLE) & req0_valid & ~gnt;
    req1_ready = ~reset & (state == IDLE) & req1_valid & gnt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      tag_q <= '0;
      port_q <= 1'b0;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_port <= 1'b0;
      resp_tag <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      if (hs) begin
        alu_a <= gnt ? req1_a : req0_a;
        alu_b <= gnt ? req1_b : req0_b;
        alu_op <= gnt ? req1_op : req0_op;
        tag_q <= gnt ? req1_tag : req0_tag;
        port_q <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        resp_valid <= 1'b1;
        resp_data <= illegal ? '0 : alu_result;
        resp_err <= illegal;
        resp_tag <= tag_q;
        resp_port <= port_q;
      end else if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      err_cnt <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
      if (state == RESP && resp_ready && resp_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
// Build with ALU_ARB_STATS_EN defined to also check the statistics counters.
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0, req0_tag = 0, req1_tag = 0;
  logic [31:0] alu_a, alu_b, alu_result, resp_data;
  logic [3:0] alu_op, resp_tag;
  logic resp_valid, resp_ready = 0, resp_port, resp_err;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
  logic [15:0] err_cnt;
`endif
  int checks = 0, errors = 0;
  int ph = 0;
  logic lg = 1'b1;
  logic m_port, m_err;
  logic [3:0] m_tag, m_op;
  logic [31:0] m_a, m_b, m_data;
  int g0 = 0, g1 = 0, ec = 0;
  logic grants[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
    .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-low-phase, then advance the model by what the edge accepts.
  task automatic tick();
    logic er0, er1;
    #1;
    er0 = ph == 0 && req0_valid && (!req1_valid || lg);
    er1 = ph == 0 && req1_valid && (!req0_valid || !lg);
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("resp_valid", resp_valid, ph == 2);
    if (ph == 1) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
    end
    if (ph == 2) begin
      chk("resp_port", resp_port, m_port);
      chk("resp_tag", resp_tag, m_tag);
      chk("resp_data", resp_data, m_data);
      chk("resp_err", resp_err, m_err);
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, g0);
    chk("grant_cnt1", grant_cnt1, g1);
    chk("err_cnt", err_cnt, ec);
`endif
    @(posedge clk);
    if (er0 || er1) begin
      m_port = er1;
      m_tag = er1 ? req1_tag : req0_tag;
      m_a = er1 ? req1_a : req0_a;
      m_b = er1 ? req1_b : req0_b;
      m_op = er1 ? req1_op : req0_op;
      m_err = m_op > 7;
      m_data = m_err ? 32'd0 : alu_f(m_a, m_b, m_op);
      lg = er1;
      grants.push_back(er1);
      if (er1) g1++; else g0++;
      ph = 1;
    end else if (ph == 1) ph = 2;
    else if (ph == 2 && resp_ready) begin
      ph = 0;
      if (m_err && ec != 16'hFFFF) ec++;
    end
    @(negedge clk);
  endtask

  initial begin
    int n, c0, c1;
    req0_valid = 1;
    req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_port", resp_port, 0);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    reset = 0;
    tick();
    // port 0 only: 5 + 3
    resp_ready = 1;
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0; req0_tag = 4'h3;
    tick();
    req0_valid = 0;
    tick();
    chk("t1_valid", resp_valid, 1);
    chk("t1_data", resp_data, 8);
    chk("t1_port", resp_port, 0);
    chk("t1_err", resp_err, 0);
    tick();
    chk("t1_idle", resp_valid, 0);
    // port 1 only: XOR
    req1_valid = 1; req1_a = 32'hF0F0F0F0; req1_b = 32'h0FF00FF0; req1_op = 4; req1_tag = 4'hA;
    tick();
    req1_valid = 0;
    tick();
    chk("t2_data", resp_data, 32'hFF00FF00);
    chk("t2_tag", resp_tag, 4'hA);
    chk("t2_port", resp_port, 1);
    tick();
    // contention: four ORs per port, grants must alternate starting with port 0
    grants.delete();
    c0 = 0; c1 = 0;
    req0_valid = 1; req1_valid = 1; req0_op = 3; req1_op = 3; req0_tag = 0; req1_tag = 8;
    for (int i = 0; i < 100 && (req0_valid || req1_valid || ph != 0); i++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      n = grants.size();
      tick();
      if (grants.size() != n) begin
        if (grants[$]) begin c1++; req1_tag++; if (c1 == 4) req1_valid = 0; end
        else begin c0++; req0_tag++; if (c0 == 4) req0_valid = 0; end
      end
    end
    chk("t3_grant_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);
    // back-pressure on the response
    resp_ready = 0;
    req1_valid = 1; req1_a = 10; req1_b = 4; req1_op = 1; req1_tag = 5;
    tick();
    req1_valid = 0;
    tick();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_data_hold", resp_data, 6);
    end
    req0_valid = 0; req1_valid = 0;
    resp_ready = 1;
    tick();
    chk("t4_done", resp_valid, 0);
    // illegal opcode
    req0_valid = 1; req0_a = 7; req0_b = 9; req0_op = 12; req0_tag = 1;
    tick();
    req0_valid = 0;
    tick();
    chk("t5_err", resp_err, 1);
    chk("t5_data", resp_data, 0);
    tick();
`ifdef ALU_ARB_STATS_EN
    chk("t5_err_cnt", err_cnt, 1);
`endif
    // reset while in EXEC aborts the transaction and restores port 0 priority
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 0; req0_tag = 2;
    tick();
    req0_valid = 0;
    req1_valid = 1;
    #1 reset = 1;
    req0_valid = 1;
    #1;
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_ready0", req0_ready, 0);
    chk("t6_ready1", req1_ready, 0);
    @(negedge clk);
    reset = 0;
    ph = 0; lg = 1; g0 = 0; g1 = 0; ec = 0;
    #1 chk("t6_first_grant", req0_ready, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();
    // random traffic
    for (int i = 0; i < 500; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15)); req0_tag = 4'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15)); req1_tag = 4'($urandom);
      resp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
